// File: rtl/delay_line_pkg.sv
// Shared types, defaults and limits for the delay_line_v5 pipeline.
package delay_line_pkg;

    localparam int DEF_REG_WIDTH = 16;
    localparam int DEF_VECTOR    = 4;
    localparam int MAX_DEPTH     = 16;

    typedef logic [DEF_REG_WIDTH-1:0] lane_t;

    typedef struct packed {
        logic                     valid;
        lane_t [DEF_VECTOR-1:0]   a;
        lane_t [DEF_VECTOR-1:0]   b;
    } stage_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipeline slot of delay_line_v5: a valid bit plus the A/B lane pair.
module delay_stage
    import delay_line_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int VECTOR    = DEF_VECTOR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_i,
    input  logic                              clear_i,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0]  a_i,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0]  b_i,
    output logic                              valid_o,
    output logic [VECTOR-1:0][REG_WIDTH-1:0]  a_o,
    output logic [VECTOR-1:0][REG_WIDTH-1:0]  b_o
);

    logic                             valid_q, valid_d;
    logic [VECTOR-1:0][REG_WIDTH-1:0] a_q, a_d;
    logic [VECTOR-1:0][REG_WIDTH-1:0] b_q, b_d;

    // Clear wins over load so a flush empties the slot even while data shifts in.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        if (load_i) begin
            valid_d = 1'b1;
            a_d     = a_i;
            b_d     = b_i;
        end
        if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;

endmodule

// File: rtl/delay_line_v5.sv
// Paired A/B vector delay line with valid/ready backpressure, bubble collapsing and flush.
// Optional occupancy counter output enabled by DELAY_LINE_OCC_EN.
module delay_line_v5
    import delay_line_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int VECTOR    = DEF_VECTOR,
    parameter int DEPTH     = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0]  a_in,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0]  b_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [VECTOR-1:0][REG_WIDTH-1:0]  a_out,
    output logic [VECTOR-1:0][REG_WIDTH-1:0]  b_out
`ifdef DELAY_LINE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]       occupancy
`endif
);

    logic [DEPTH-1:0]                 valid_w;
    logic [DEPTH-1:0]                 adv;
    logic [DEPTH-1:0]                 load;
    logic [DEPTH-1:0]                 clear;
    logic [VECTOR-1:0][REG_WIDTH-1:0] a_w   [DEPTH];
    logic [VECTOR-1:0][REG_WIDTH-1:0] b_w   [DEPTH];
    logic [VECTOR-1:0][REG_WIDTH-1:0] a_src [DEPTH];
    logic [VECTOR-1:0][REG_WIDTH-1:0] b_src [DEPTH];
    logic                             room;
    logic                             accept;
    logic                             pop;

    // A stage may move iff the head is being popped or any later stage is empty;
    // scanning from the head keeps the chain free of combinational feedback.
    always_comb begin
        room = out_ready;
        adv  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = valid_w[i] & room;
            room   = room | ~valid_w[i];
        end
        in_ready = ~flush & room;
    end

    assign accept = in_valid & in_ready;
    assign pop    = adv[DEPTH-1];

    always_comb begin
        load     = '0;
        a_src[0] = a_in;
        b_src[0] = b_in;
        load[0]  = accept;
        for (int i = 1; i < DEPTH; i++) begin
            load[i]  = adv[i-1];
            a_src[i] = a_w[i-1];
            b_src[i] = b_w[i-1];
        end
        clear = {DEPTH{flush}} | (adv & ~load);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        delay_stage #(
            .REG_WIDTH (REG_WIDTH),
            .VECTOR    (VECTOR)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[g]),
            .clear_i (clear[g]),
            .a_i     (a_src[g]),
            .b_i     (b_src[g]),
            .valid_o (valid_w[g]),
            .a_o     (a_w[g]),
            .b_o     (b_w[g])
        );
    end

    assign out_valid = valid_w[DEPTH-1];
    assign a_out     = a_w[DEPTH-1];
    assign b_out     = b_w[DEPTH-1];

`ifdef DELAY_LINE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
